// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: computes a - b one bit pair per cycle, LSB first,
// reporting diff (mod 2^WIDTH) and the final borrow after WIDTH shift cycles.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic [1:0]       dbg_state
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res;
  logic             bflop;
  logic [CW-1:0]    cnt;
  logic             accept;
  logic             x;
  logic             y;
  logic             d;
  logic             bout;

  // start is a request qualified by the FSM: it is taken only in IDLE or DONE
  // (never while busy); done is a one-cycle pulse with diff/borrow valid and
  // held until the next accepted start.
  assign accept = start && ((state == S_IDLE) || (state == S_DONE));

  always_comb begin
    x    = a_sr[0];
    y    = b_sr[0];
    d    = x ^ y ^ bflop;
    bout = (~x & y) | (~(x ^ y) & bflop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      a_sr  <= '0;
      b_sr  <= '0;
      res   <= '0;
      bflop <= 1'b0;
      cnt   <= '0;
    end else if (accept) begin
      state <= S_SHIFT;
      a_sr  <= a;
      b_sr  <= b;
      bflop <= 1'b0;
      cnt   <= '0;
    end else if (state == S_SHIFT) begin
      // Result fills from the top so bit 0 lands in place after WIDTH shifts.
      res   <= {d, res[WIDTH-1:1]};
      bflop <= bout;
      a_sr  <= a_sr >> 1;
      b_sr  <= b_sr >> 1;
      cnt   <= cnt + CW'(1);
      if (cnt == LAST_BIT) begin
        state <= S_DONE;
      end
    end else if (state == S_DONE) begin
      state <= S_IDLE;
    end
  end

  assign busy      = (state == S_SHIFT);
  assign done      = (state == S_DONE);
  assign diff      = res;
  assign borrow    = bflop;
  assign dbg_state = state;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8): directed scenarios plus
// randomized operands checked against a plain-arithmetic reference.
module tb_serial_subtractor;

  localparam int W = 8;
  localparam int TIMEOUT = 4 * W;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow;
  logic [1:0]   dbg_state;

  int vectors = 0;
  int errors  = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .diff      (diff),
    .borrow    (borrow),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  // Reference: unsigned subtraction wrapped to W bits, borrow when x < y.
  function automatic logic [W:0] ref_sub(input logic [W-1:0] x, input logic [W-1:0] y);
    int r;
    logic [W-1:0] dv;
    r = int'(x) - int'(y);
    if (r < 0) r = r + (1 << W);
    dv = r[W-1:0];
    return {(x < y), dv};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [W-1:0] x, input logic [W-1:0] y);
    start = 1'b1;
    a = x;
    b = y;
    tick();
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
  endtask

  task automatic wait_done(output int busy_cycles, output bit ok);
    busy_cycles = 0;
    ok = 1'b0;
    for (int i = 0; i < TIMEOUT; i++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      if (busy) busy_cycles++;
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b1;
    a = 8'h33;
    b = 8'h11;
    tick();
    tick();
    vectors++;
    if ({busy, done, diff, borrow, dbg_state} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b done=%b diff=%h borrow=%b state=%0d, required all 0",
               busy, done, diff, borrow, dbg_state);
    end
    // Start must be taken on the very first edge after reset falls.
    reset = 1'b0;
    a = 8'h0C;
    b = 8'h04;
    tick();
    start = 1'b0;
    vectors++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL first_start_after_reset: busy=%b, required 1", busy);
    end
    begin
      int bc;
      bit ok;
      wait_done(bc, ok);
      vectors++;
      if (!ok || diff !== 8'h08 || borrow !== 1'b0) begin
        errors++;
        $display("FAIL first_op_result: ok=%b diff=%h borrow=%b, required 1/08/0", ok, diff, borrow);
      end
    end
    tick();
  endtask

  task automatic test_simple();
    int bc;
    bit ok;
    do_start(8'd5, 8'd3);
    wait_done(bc, ok);
    vectors++;
    if (!ok || bc != W) begin
      errors++;
      $display("FAIL simple_busy_len: ok=%b busy_cycles=%0d, required 1/%0d", ok, bc, W);
    end
    vectors++;
    if (diff !== 8'h02 || borrow !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL simple_result: diff=%h borrow=%b busy=%b, required 02/0/0", diff, borrow, busy);
    end
    tick();
    vectors++;
    if (done !== 1'b0 || diff !== 8'h02) begin
      errors++;
      $display("FAIL simple_done_pulse: done=%b diff=%h, required 0/02", done, diff);
    end
  endtask

  task automatic test_negative();
    int bc;
    bit ok;
    do_start(8'd3, 8'd5);
    wait_done(bc, ok);
    vectors++;
    if (!ok || diff !== 8'hFE || borrow !== 1'b1) begin
      errors++;
      $display("FAIL negative_result: ok=%b diff=%h borrow=%b, required 1/fe/1", ok, diff, borrow);
    end
    for (int i = 0; i < 3; i++) begin
      a = W'($urandom);
      b = W'($urandom);
      tick();
      vectors++;
      if (done !== 1'b0 || diff !== 8'hFE || borrow !== 1'b1) begin
        errors++;
        $display("FAIL negative_hold[%0d]: done=%b diff=%h borrow=%b, required 0/fe/1",
                 i, done, diff, borrow);
      end
    end
  endtask

  task automatic test_boundaries();
    logic [W-1:0] ta[3] = '{8'h00, 8'hFF, 8'hA5};
    logic [W-1:0] tb[3] = '{8'hFF, 8'h00, 8'hA5};
    logic [W:0]   te[3] = '{{1'b1, 8'h01}, {1'b0, 8'hFF}, {1'b0, 8'h00}};
    int bc;
    bit ok;
    for (int i = 0; i < 3; i++) begin
      do_start(ta[i], tb[i]);
      wait_done(bc, ok);
      vectors++;
      if (!ok || {borrow, diff} !== te[i] || {borrow, diff} !== ref_sub(ta[i], tb[i])) begin
        errors++;
        $display("FAIL boundary %h-%h: ok=%b diff=%h borrow=%b, required %h/%b",
                 ta[i], tb[i], ok, diff, borrow, te[i][W-1:0], te[i][W]);
      end
      tick();
    end
  endtask

  task automatic test_start_busy();
    int bc;
    bit ok;
    do_start(8'd9, 8'd4);
    tick();
    tick();
    start = 1'b1;
    a = 8'd0;
    b = 8'd1;
    tick();
    start = 1'b0;
    wait_done(bc, ok);
    vectors++;
    if (!ok || bc != W - 3) begin
      errors++;
      $display("FAIL start_busy_timing: ok=%b remaining_busy=%0d, required 1/%0d", ok, bc, W - 3);
    end
    vectors++;
    if (diff !== 8'h05 || borrow !== 1'b0) begin
      errors++;
      $display("FAIL start_busy_result: diff=%h borrow=%b, required 05/0", diff, borrow);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W:0]   e;
    int bc;
    bit ok;
    x = W'($urandom);
    y = W'($urandom);
    e = ref_sub(x, y);
    do_start(x, y);
    wait_done(bc, ok);
    vectors++;
    if (!ok || {borrow, diff} !== e) begin
      errors++;
      $display("FAIL b2b_first: ok=%b diff=%h borrow=%b, required %h/%b", ok, diff, borrow, e[W-1:0], e[W]);
    end
    start = 1'b1;
    a = 8'h10;
    b = 8'h20;
    tick();
    start = 1'b0;
    vectors++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_reenter: busy=%b done=%b, required 1/0", busy, done);
    end
    wait_done(bc, ok);
    vectors++;
    if (!ok || (1 + bc) != W + 1) begin
      errors++;
      $display("FAIL b2b_gap: ok=%b gap=%0d, required 1/%0d", ok, 1 + bc, W + 1);
    end
    vectors++;
    if (diff !== 8'hF0 || borrow !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second: diff=%h borrow=%b, required f0/1", diff, borrow);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int bc;
    int done_seen;
    bit ok;
    do_start(8'hC3, 8'h11);
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    vectors++;
    if ({busy, done, diff, borrow, dbg_state} !== '0) begin
      errors++;
      $display("FAIL reset_mid_outputs: busy=%b done=%b diff=%h borrow=%b state=%0d, required all 0",
               busy, done, diff, borrow, dbg_state);
    end
    reset = 1'b0;
    done_seen = 0;
    for (int i = 0; i < W + 3; i++) begin
      tick();
      if (done || busy) done_seen++;
    end
    vectors++;
    if (done_seen != 0) begin
      errors++;
      $display("FAIL reset_mid_no_done: activity_cycles=%0d, required 0", done_seen);
    end
    do_start(8'd7, 8'd2);
    wait_done(bc, ok);
    vectors++;
    if (!ok || diff !== 8'h05 || borrow !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_recover: ok=%b diff=%h borrow=%b, required 1/05/0", ok, diff, borrow);
    end
    tick();
  endtask

  task automatic test_random();
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W:0]   e;
    int bc;
    bit ok;
    for (int n = 0; n < 40; n++) begin
      x = W'($urandom);
      y = W'($urandom);
      e = ref_sub(x, y);
      do_start(x, y);
      wait_done(bc, ok);
      vectors++;
      if (!ok || bc != W || {borrow, diff} !== e) begin
        errors++;
        $display("FAIL random %h-%h: ok=%b busy=%0d diff=%h borrow=%b, required %h/%b",
                 x, y, ok, bc, diff, borrow, e[W-1:0], e[W]);
      end
      for (int g = 0; g < $urandom_range(0, 3); g++) tick();
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    test_reset();
    test_simple();
    test_negative();
    test_boundaries();
    test_start_busy();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand and result width in bits (legal range 2..32).
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge only.
REQ-003 reset  input  1  reset, synchronous and active-high.
REQ-004 start  input  1  request to begin a subtraction, sampled on the rising edge of clk.
REQ-005 a  input  WIDTH  minuend, unsigned, captured on an accepted start.
REQ-006 b  input  WIDTH  subtrahend, unsigned, captured on an accepted start.
REQ-007 busy  output  1  high while a subtraction is in progress.
REQ-008 done  output  1  single-cycle pulse marking diff and borrow valid.
REQ-009 diff  output  WIDTH  result, a - b modulo 2^WIDTH.
REQ-010 borrow  output  1  final borrow-out, high when a < b.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-012 In IDLE or DONE, start=1 SHALL be accepted, with these effects:
- a and b load into internal shift registers;
- the borrow flop and the bit counter clear to 0;
- the next state is SHIFT.
REQ-013 In SHIFT, each cycle SHALL process one bit pair, LSB first, as follows:
- with x = a_sr[0], y = b_sr[0], bin = borrow flop:
- d = x ^ y ^ bin;
- bout = (~x & y) | (~(x ^ y) & bin).
REQ-014 In each SHIFT cycle, d SHALL shift into the MSB of the result register, bout SHALL load the borrow flop, a_sr and b_sr SHALL shift right by one, and the counter SHALL increment.
REQ-015 SHIFT SHALL last exactly WIDTH cycles, after which the state SHALL become DONE.
REQ-016 The counter SHALL be ceil(log2(WIDTH+1)) bits wide, and the SHIFT-to-DONE transition SHALL occur on the cycle that processes bit WIDTH-1.
REQ-017 DONE SHALL last one cycle and then go to IDLE, unless start=1 in that cycle, in which case REQ-012 SHALL apply.
REQ-018 busy SHALL equal 1 exactly when the state is SHIFT.
REQ-019 done SHALL equal 1 exactly when the state is DONE.
REQ-020 Latency: with start accepted at edge N, done SHALL be high in the cycle after edge N+WIDTH, giving a throughput of one result per WIDTH+1 cycles.
REQ-021 diff and borrow SHALL be driven from registers, SHALL hold their final values from DONE until the next accepted start, and SHALL not be guaranteed valid while busy=1.
REQ-022 start=1 while busy=1 SHALL be ignored, with no reload and no effect on the in-flight operation.
REQ-023 Changes on a or b while not accepting a start SHALL not affect the result.
REQ-024 Boundary results SHALL be as follows:
- a == b SHALL give diff = 0 and borrow = 0;
- a = 0, b = 2^WIDTH-1 SHALL give diff = 1 and borrow = 1;
- a = 2^WIDTH-1, b = 0 SHALL give diff = 2^WIDTH-1 and borrow = 0.
REQ-025 All outputs SHALL be registered, with no combinational path from any input to any output.

Reset
REQ-026 While reset=1, the state SHALL be IDLE and busy, done, diff, borrow, the counter and the shift registers SHALL all be 0.
REQ-027 reset SHALL take priority over start, and reset asserted mid-SHIFT SHALL abort the operation in the same edge with no done pulse.
REQ-028 The first start SHALL be accepted on the first edge after reset is deasserted.

Verification (WIDTH=8)
REQ-029 Simple subtraction: reset, then start with a=5, b=3; the bench SHALL check busy=1 for 8 cycles, then done=1 for one cycle, with diff=0x02 and borrow=0.
REQ-030 Negative result: a=3, b=5; the bench SHALL check diff=0xFE and borrow=1, and that both hold after done falls.
REQ-031 Boundaries: the bench SHALL run 0x00-0xFF, 0xFF-0x00 and 0xA5-0xA5 and check for 0x01/1, 0xFF/0 and 0x00/0 respectively.
REQ-032 Start while busy: start a=9, b=4, pulse start with a=0, b=1 in SHIFT cycle 3, and the bench SHALL check diff=0x05 and borrow=0 at done.
REQ-033 Back-to-back: hold start=1 during DONE with new operands 0x10-0x20, and the bench SHALL check that SHIFT re-enters immediately and the second done gives diff=0xF0, borrow=1, exactly 9 cycles after the first done.
REQ-034 Reset mid-operation: assert reset in SHIFT cycle 4, and the bench SHALL check that all outputs are 0 on the next edge, no done occurs, and a subsequent 7-2 returns 0x05/0.
